// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side bundle of the buffered UART receiver (serial line, pop/clear strobes, FIFO head and status).
interface uart_rx_if;
    logic       rx;
    logic       read_data;
    logic       clear_errors;
    logic [7:0] data_rx;
    logic       data_available;
    logic       frame_error;
    logic       overflow;
    logic       is_busy;
    modport master (
        output rx, read_data, clear_errors,
        input  data_rx, data_available, frame_error, overflow, is_busy
    );
    modport slave (
        input  rx, read_data, clear_errors,
        output data_rx, data_available, frame_error, overflow, is_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: buffered 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as the majority of three samples.
module uart_rx #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [BCW-1:0] BIT_LOAD = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LOAD = BCW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
    state_t                     state;
    logic [1:0]                 sync;
    logic                       rx_s, bit_s, at_sample, stop_ok, push, pop, full;
    logic [BCW-1:0]             bc;
    logic [2:0]                 idx;
    logic [7:0]                 shift;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] head, tail;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       busy, fe, ovf;
    assign rx_s = sync[1];
    assign at_sample = busy && bc == '0;
    assign full = count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    assign stop_ok = state == STOP && at_sample && bit_s;
    assign push = stop_ok && !full;
    assign pop = bus.read_data && count != '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic v2, v1;
    assign bit_s = (v2 & v1) | (v2 & rx_s) | (v1 & rx_s);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            if (bc == BCW'(2)) v2 <= rx_s;
            if (bc == BCW'(1)) v1 <= rx_s;
        end
    end
`else
    assign bit_s = rx_s;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= WAIT_IDLE;
            bc    <= '0;
            idx   <= '0;
            shift <= '0;
            busy  <= 1'b0;
            fe    <= 1'b0;
        end else begin
            sync <= {sync[0], bus.rx};
            fe   <= 1'b0;
            if (bc != '0) bc <= bc - 1'b1;
            case (state)
                WAIT_IDLE: if (rx_s) state <= IDLE;
                IDLE: if (!rx_s) begin
                    state <= START;
                    bc    <= HALF_LOAD;
                    busy  <= 1'b1;
                end
                START: if (at_sample) begin
                    state <= bit_s ? IDLE : DATA;
                    busy  <= !bit_s;
                    idx   <= '0;
                    bc    <= BIT_LOAD;
                end
                DATA: if (at_sample) begin
                    shift <= {bit_s, shift[7:1]};
                    idx   <= idx + 1'b1;
                    bc    <= BIT_LOAD;
                    if (idx == 3'd7) state <= STOP;
                end
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught on time.
                STOP: if (at_sample) begin
                    state <= bit_s ? IDLE : WAIT_IDLE;
                    fe    <= !bit_s;
                    busy  <= 1'b0;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) if (push) mem[tail] <= shift;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (FIFO_DEPTH_LOG2 + 1)'(push) - (FIFO_DEPTH_LOG2 + 1)'(pop);
            ovf   <= (stop_ok && full) || (ovf && !bus.clear_errors);
        end
    end
    assign bus.data_rx = count != '0 ? mem[head] : 8'h00;
    assign bus.data_available = count != '0;
    assign bus.frame_error = fe;
    assign bus.overflow = ovf;
    assign bus.is_busy = busy;
endmodule
